cmd_frame_master: RTL and testbench
===================================

CMD_FRAME_MASTER -- requirements
Module: cmd_frame_master

Interface
REQ-001 SHALL have parameter TOUT_CYC, 16'd50000, the number of idle cycles between received bytes after which a partial frame is aborted.
REQ-002 SHALL have parameter RD_LAT, 2, the number of cycles from an rd_adr change to my_dat being sampled (range 1..7).
REQ-003 SHALL have one clock and an asynchronous active-low reset; ports clk and rst_n are listed first below.
REQ-004 clk  in  1  system clock; all state changes on posedge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 rx_dat  in  8  received byte from the UART receiver.
REQ-007 rx_ce  in  1  one-cycle strobe marking rx_dat valid.
REQ-008 tx_dat  out  8  byte to the UART transmitter.
REQ-009 tx_ce  out  1  one-cycle strobe that launches tx_dat.
REQ-010 tx_rdy  in  1  transmitter idle; ignored in the cycle after tx_ce.
REQ-011 com  out  8  command presented to register/memory slaves.
REQ-012 wr_adr  out  16  slave write address.
REQ-013 rd_adr  out  16  slave read address.
REQ-014 wr_dat  out  8  slave write data (feeds the slave rx_dat).
REQ-015 ce_wr_dat  out  1  one-cycle slave write strobe.
REQ-016 my_dat  in  8  slave read data.
REQ-017 crc_err  out  1  one-cycle pulse on a frame CRC mismatch.

Function
REQ-018 SHALL parse frames of the form [cmd][adr_hi][adr_lo][len][len data bytes, write commands only][crc].
REQ-019 SHALL compute CRC-8 with polynomial 0x07, init 0x00, MSB first, with no reflection and no xorout, over all bytes preceding the crc byte; "123456789" yields 0xF4.
REQ-020 SHALL use FSM states IDLE, ADR_H, ADR_L, LEN, DATA, CHK, RD_SET, RD_WAIT, RD_SEND, CRC_SEND, ACK_SEND.
REQ-021 SHALL accept cmd values 00 (register write), C1 (memory write), 80 (register read) and 81 (memory read); any other byte in IDLE SHALL be discarded and the FSM SHALL stay in IDLE.
REQ-022 SHALL drive com = 8'hFF in IDLE; com = cmd from LEN onward, except that C1 SHALL be driven as 8'h81; com SHALL return to 8'hFF on frame end.
REQ-023 For write frames, each data byte SHALL assert ce_wr_dat for exactly one cycle, on the cycle after its rx_ce, with wr_dat = byte and wr_adr = adr+i (16-bit wrap at FFFF->0000).
REQ-024 wr_adr SHALL read 16'hFFFF in every cycle where ce_wr_dat is low, and rd_adr SHALL read 16'hFFFF outside RD_SET, RD_WAIT and RD_SEND.
REQ-025 Writes SHALL be issued on the fly; a CRC error detected in CHK SHALL NOT undo writes already issued.
REQ-026 len = 0 on a write frame SHALL go directly to CHK.
REQ-027 For read frames, the crc byte follows len directly; if the CRC matches, the block SHALL read adr..adr+len-1 (len = 0 means 256) and send each byte, then send the CRC-8 of the sent bytes.
REQ-028 Each read SHALL present rd_adr, wait RD_LAT cycles, sample my_dat, then transmit that byte.
REQ-029 SHALL emit tx_ce only when tx_rdy = 1, and SHALL emit at most one tx_ce per tx_rdy high period.
REQ-030 On a CRC mismatch, crc_err SHALL pulse for 1 cycle on the cycle after the crc byte's rx_ce; no reads SHALL be issued.
REQ-031 In states ADR_H through CHK, TOUT_CYC cycles without rx_ce SHALL abort the frame to IDLE with no crc_err pulse.
REQ-032 rx_ce SHALL be ignored during RD_* and *_SEND states, and received bytes SHALL be dropped there.
REQ-033 A CRC mismatch SHALL NOT pulse crc_err for a frame already aborted by timeout.

Reset
REQ-034 rst_n low SHALL asynchronously force state IDLE, com = FF, wr_adr = rd_adr = FFFF, wr_dat = 00, tx_dat = 00, ce_wr_dat = tx_ce = crc_err = 0, the CRC register and the counters to 0.
REQ-035 Reset asserted mid-frame or mid-transmission SHALL drop the frame entirely; no strobe SHALL appear in the first cycle after release.

Configuration
REQ-036 SHALL support the macro CMD_ACK_EN.
REQ-037 When CMD_ACK_EN is defined, every write frame SHALL end with the transmission of one byte: A5 on a good CRC, E1 on a bad CRC; a read frame with a bad CRC SHALL transmit E1.
REQ-038 When CMD_ACK_EN is undefined, write frames and bad-CRC frames SHALL transmit nothing, and ACK_SEND SHALL be unreachable.

Verification
REQ-039 Frame 00 0F 00 03 11 22 33 + crc -> three ce_wr_dat pulses at wr_adr 0F00/0F01/0F02 with data 11/22/33; with CMD_ACK_EN, tx A5.
REQ-040 Frame 81 0F 10 04 + crc, with a slave model of RD_LAT = 2 returning mem[a] = a[7:0] -> tx 10 11 12 13 then the CRC-8 of those four bytes.
REQ-041 Write frame with the crc byte XOR 01 -> crc_err one-cycle pulse, data writes still seen; with CMD_ACK_EN tx E1; read frame with a bad crc -> zero rd_adr changes.
REQ-042 Send three header bytes, then idle for TOUT_CYC+1 cycles, then a valid frame -> first frame dropped silently, second executes normally.
REQ-043 Write at adr FFFF with len 2 -> wr_adr FFFF then 0000; hold tx_rdy low for 100 cycles during a read reply -> no tx_ce until tx_rdy rises, and no byte lost.
REQ-044 Assert rst_n low during the 2nd data byte -> all outputs at their reset values immediately; the next valid frame executes.

Source files
------------

// File: rtl/cmd_frame_master_if.sv
// Byte-stream and slave-bus bundle for cmd_frame_master.
// master: the frame parser; slave: UART endpoints and register/memory slaves.
interface cmd_frame_master_if;
  logic [7:0]  rx_dat;
  logic        rx_ce;
  logic [7:0]  tx_dat;
  logic        tx_ce;
  logic        tx_rdy;
  logic [7:0]  com;
  logic [15:0] wr_adr;
  logic [15:0] rd_adr;
  logic [7:0]  wr_dat;
  logic        ce_wr_dat;
  logic [7:0]  my_dat;
  logic        crc_err;

  modport master (
    input  rx_dat, rx_ce, tx_rdy, my_dat,
    output tx_dat, tx_ce, com, wr_adr, rd_adr, wr_dat, ce_wr_dat, crc_err
  );
  modport slave (
    output rx_dat, rx_ce, tx_rdy, my_dat,
    input  tx_dat, tx_ce, com, wr_adr, rd_adr, wr_dat, ce_wr_dat, crc_err
  );
endinterface

// File: rtl/cmd_frame_master.sv
// UART command frame master: parses [cmd][adr_hi][adr_lo][len][data..][crc8], issues slave writes/reads.
// Optional macro CMD_ACK_EN: write frames and bad-CRC frames answer with one status byte (A5 / E1).
module cmd_frame_master #(
  parameter logic [15:0] TOUT_CYC = 16'd50000,
  parameter int unsigned RD_LAT   = 2
) (
  input logic                clk,
  input logic                rst_n,
  cmd_frame_master_if.master bus
);
  typedef enum logic [3:0] {
    IDLE, ADR_H, ADR_L, LEN, DATA, CHK, RD_SET, RD_WAIT, RD_SEND, CRC_SEND, ACK_SEND
  } state_t;

  localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d, len_q, len_d, crc_q, crc_d, rdat_q, rdat_d;
  logic [7:0]  wr_dat_q, wr_dat_d, tx_dat_q, tx_dat_d;
  logic [15:0] adr_q, adr_d, wr_adr_q, wr_adr_d, tout_q, tout_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [2:0]  lat_q, lat_d;
  logic        ce_wr_q, ce_wr_d, tx_ce_q, tx_ce_d, crc_err_q, crc_err_d, used_q, used_d;
`ifdef CMD_ACK_EN
  logic [7:0]  ack_q, ack_d;
`endif

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c ^ b;
    for (int i = 0; i < 8; i++) r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    return r;
  endfunction

  logic       is_rd, cmd_ok, in_hdr, in_rd, tx_ok, tout_hit;
  logic [8:0] rd_tot;

  assign is_rd    = (cmd_q == 8'h80) || (cmd_q == 8'h81);
  assign cmd_ok   = bus.rx_dat inside {8'h00, 8'hC1, 8'h80, 8'h81};
  assign in_hdr   = state_q inside {ADR_H, ADR_L, LEN, DATA, CHK};
  assign in_rd    = state_q inside {RD_SET, RD_WAIT, RD_SEND};
  assign rd_tot   = (len_q == 8'd0) ? 9'd256 : {1'b0, len_q};
  // used_q blocks a second launch until the transmitter has visibly dropped tx_rdy
  assign tx_ok    = bus.tx_rdy & ~used_q;
  assign tout_hit = in_hdr & ~bus.rx_ce & (tout_q == TOUT_CYC - 16'd1);

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    len_d     = len_q;
    crc_d     = crc_q;
    rdat_d    = rdat_q;
    adr_d     = adr_q;
    cnt_d     = cnt_q;
    lat_d     = lat_q;
    wr_dat_d  = wr_dat_q;
    tx_dat_d  = tx_dat_q;
    wr_adr_d  = 16'hFFFF;
    ce_wr_d   = 1'b0;
    tx_ce_d   = 1'b0;
    crc_err_d = 1'b0;
    used_d    = bus.tx_rdy ? used_q : 1'b0;
    tout_d    = (in_hdr && !bus.rx_ce) ? tout_q + 16'd1 : 16'd0;
`ifdef CMD_ACK_EN
    ack_d     = ack_q;
`endif
    case (state_q)
      IDLE: if (bus.rx_ce && cmd_ok) begin
        cmd_d   = bus.rx_dat;
        crc_d   = crc8(8'h00, bus.rx_dat);
        state_d = ADR_H;
      end
      ADR_H: if (bus.rx_ce) begin
        adr_d[15:8] = bus.rx_dat;
        crc_d       = crc8(crc_q, bus.rx_dat);
        state_d     = ADR_L;
      end
      ADR_L: if (bus.rx_ce) begin
        adr_d[7:0] = bus.rx_dat;
        crc_d      = crc8(crc_q, bus.rx_dat);
        state_d    = LEN;
      end
      LEN: if (bus.rx_ce) begin
        len_d   = bus.rx_dat;
        cnt_d   = 9'd0;
        crc_d   = crc8(crc_q, bus.rx_dat);
        state_d = (is_rd || bus.rx_dat == 8'd0) ? CHK : DATA;
      end
      DATA: if (bus.rx_ce) begin
        wr_dat_d = bus.rx_dat;
        wr_adr_d = adr_q + 16'(cnt_q);
        ce_wr_d  = 1'b1;
        crc_d    = crc8(crc_q, bus.rx_dat);
        cnt_d    = cnt_q + 9'd1;
        if (cnt_q + 9'd1 == {1'b0, len_q}) state_d = CHK;
      end
      CHK: if (bus.rx_ce) begin
        cnt_d = 9'd0;
        crc_d = 8'h00;  // reused for the CRC of the read reply
        if (bus.rx_dat == crc_q) begin
`ifdef CMD_ACK_EN
          ack_d   = 8'hA5;
          state_d = is_rd ? RD_SET : ACK_SEND;
`else
          state_d = is_rd ? RD_SET : IDLE;
`endif
        end else begin
          crc_err_d = 1'b1;
`ifdef CMD_ACK_EN
          ack_d     = 8'hE1;
          state_d   = ACK_SEND;
`else
          state_d   = IDLE;
`endif
        end
      end
      RD_SET: begin
        lat_d = 3'd1;
        if (RD_LAT <= 1) begin
          rdat_d  = bus.my_dat;
          state_d = RD_SEND;
        end else begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (lat_q >= LAT_M1) begin
          rdat_d  = bus.my_dat;
          state_d = RD_SEND;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      RD_SEND: if (tx_ok) begin
        tx_ce_d  = 1'b1;
        tx_dat_d = rdat_q;
        used_d   = 1'b1;
        crc_d    = crc8(crc_q, rdat_q);
        cnt_d    = cnt_q + 9'd1;
        state_d  = (cnt_q + 9'd1 == rd_tot) ? CRC_SEND : RD_SET;
      end
      CRC_SEND: if (tx_ok) begin
        tx_ce_d  = 1'b1;
        tx_dat_d = crc_q;
        used_d   = 1'b1;
        state_d  = IDLE;
      end
      ACK_SEND: begin
`ifdef CMD_ACK_EN
        if (tx_ok) begin
          tx_ce_d  = 1'b1;
          tx_dat_d = ack_q;
          used_d   = 1'b1;
          state_d  = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
    if (tout_hit) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cmd_q     <= 8'h00;
      len_q     <= 8'h00;
      crc_q     <= 8'h00;
      rdat_q    <= 8'h00;
      adr_q     <= 16'h0000;
      cnt_q     <= 9'd0;
      lat_q     <= 3'd0;
      wr_dat_q  <= 8'h00;
      tx_dat_q  <= 8'h00;
      wr_adr_q  <= 16'hFFFF;
      ce_wr_q   <= 1'b0;
      tx_ce_q   <= 1'b0;
      crc_err_q <= 1'b0;
      used_q    <= 1'b0;
      tout_q    <= 16'd0;
`ifdef CMD_ACK_EN
      ack_q     <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      len_q     <= len_d;
      crc_q     <= crc_d;
      rdat_q    <= rdat_d;
      adr_q     <= adr_d;
      cnt_q     <= cnt_d;
      lat_q     <= lat_d;
      wr_dat_q  <= wr_dat_d;
      tx_dat_q  <= tx_dat_d;
      wr_adr_q  <= wr_adr_d;
      ce_wr_q   <= ce_wr_d;
      tx_ce_q   <= tx_ce_d;
      crc_err_q <= crc_err_d;
      used_q    <= used_d;
      tout_q    <= tout_d;
`ifdef CMD_ACK_EN
      ack_q     <= ack_d;
`endif
    end
  end

  assign bus.com       = (state_q inside {IDLE, ADR_H, ADR_L}) ? 8'hFF :
                         (cmd_q == 8'hC1) ? 8'h81 : cmd_q;
  assign bus.rd_adr    = in_rd ? adr_q + 16'(cnt_q) : 16'hFFFF;
  assign bus.wr_adr    = wr_adr_q;
  assign bus.wr_dat    = wr_dat_q;
  assign bus.ce_wr_dat = ce_wr_q;
  assign bus.tx_dat    = tx_dat_q;
  assign bus.tx_ce     = tx_ce_q;
  assign bus.crc_err   = crc_err_q;
endmodule

// File: tb/tb_cmd_frame_master.sv
// Directed bench for cmd_frame_master: writes, reads, CRC errors, timeout, wrap, tx back-pressure, reset.
module tb_cmd_frame_master;
  localparam logic [15:0] TOUT = 16'd40;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  cmd_frame_master_if bus();
  cmd_frame_master #(.TOUT_CYC(TOUT), .RD_LAT(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0, fails = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // transmitter: busy for 3 cycles after each launch; hold forces it not-ready
  logic       hold = 1'b0;
  logic [2:0] busy = 3'd0;
  assign bus.tx_rdy = (busy == 3'd0) && !hold;
  always @(posedge clk) begin
    if (bus.tx_ce) busy <= 3'd3;
    else if (busy != 3'd0) busy <= busy - 3'd1;
  end

  // slave memory mem[a] = a[7:0], registered read
  always @(posedge clk) bus.my_dat <= bus.rd_adr[7:0];

  logic [15:0] wa_q[$];
  logic [7:0]  wd_q[$], tx_q[$];
  int n_err = 0, n_rdchg = 0, n_badadr = 0, n_txviol = 0;
  logic [15:0] rd_prev = 16'hFFFF;
  always @(negedge clk) begin
    if (bus.ce_wr_dat) begin
      wa_q.push_back(bus.wr_adr);
      wd_q.push_back(bus.wr_dat);
    end else if (bus.wr_adr !== 16'hFFFF) n_badadr++;
    if (bus.tx_ce) begin
      tx_q.push_back(bus.tx_dat);
      if (!bus.tx_rdy) n_txviol++;
    end
    if (bus.crc_err) n_err++;
    if (bus.rd_adr !== rd_prev) n_rdchg++;
    rd_prev = bus.rd_adr;
  end

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c ^ b;
    for (int i = 0; i < 8; i++) r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    return r;
  endfunction

  function automatic logic [7:0] crc_of(input logic [7:0] q[$]);
    logic [7:0] c = 8'h00;
    foreach (q[i]) c = crc8(c, q[i]);
    return c;
  endfunction

  logic [7:0] fr[$];
  logic last_ce, last_err;

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.rx_dat = b;
    bus.rx_ce  = 1'b1;
    @(negedge clk);
    last_ce  = bus.ce_wr_dat;
    last_err = bus.crc_err;
    bus.rx_ce = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] xr);
    logic [7:0] c;
    c = crc_of(fr);
    foreach (fr[i]) send(fr[i]);
    send(c ^ xr);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    @(posedge clk);
    wa_q.delete(); wd_q.delete(); tx_q.delete();
    n_err = 0; n_rdchg = 0;
  endtask

  task automatic wait_tx(input int n, input string tag);
    int k = 0;
    while (tx_q.size() < n && k < 3000) begin
      @(posedge clk);
      k++;
    end
    idle(1);
    chk(tag, tx_q.size(), n);
  endtask

  initial begin
    logic [7:0] c, rc;
    bus.rx_dat = 8'h00;
    bus.rx_ce  = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_com", bus.com, 8'hFF);
    chk("rst_adr", {bus.wr_adr, bus.rd_adr}, 32'hFFFF_FFFF);
    chk("rst_dat", {bus.wr_dat, bus.tx_dat}, 16'h0000);
    chk("rst_strb", {bus.ce_wr_dat, bus.tx_ce, bus.crc_err}, 3'b000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // invalid cmd discarded, then register write
    clr();
    send(8'h55);
    fr = '{8'h00, 8'h0F, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
    c = crc_of(fr);
    for (int i = 0; i < 4; i++) send(fr[i]);
    chk("com_wr", bus.com, 8'h00);
    chk("hdr_no_ce", last_ce, 1'b0);
    send(fr[4]);
    chk("ce_timing", last_ce, 1'b1);
    send(fr[5]); send(fr[6]); send(c);
    idle(3);
    chk("wr_cnt", wa_q.size(), 3);
    chk("wr0", {wa_q[0], wd_q[0]}, {16'h0F00, 8'h11});
    chk("wr1", {wa_q[1], wd_q[1]}, {16'h0F01, 8'h22});
    chk("wr2", {wa_q[2], wd_q[2]}, {16'h0F02, 8'h33});
    chk("wr_noerr", n_err, 0);
    chk("com_end", bus.com, 8'hFF);
`ifdef CMD_ACK_EN
    wait_tx(1, "ack_cnt");
    chk("ack_ok", tx_q[0], 8'hA5);
`else
    idle(20);
    chk("no_tx_wr", tx_q.size(), 0);
`endif

    // memory read of 4 bytes
    clr();
    fr = '{8'h81, 8'h0F, 8'h10, 8'h04};
    send_frame(8'h00);
    chk("com_rd", bus.com, 8'h81);
    wait_tx(5, "rd_cnt");
    chk("rd0", tx_q[0], 8'h10);
    chk("rd1", tx_q[1], 8'h11);
    chk("rd2", tx_q[2], 8'h12);
    chk("rd3", tx_q[3], 8'h13);
    rc = crc_of('{8'h10, 8'h11, 8'h12, 8'h13});
    chk("rd_crc", tx_q[4], rc);
    chk("rd_nowr", wa_q.size(), 0);

    // bad-CRC memory write: writes stay, one-cycle crc_err
    clr();
    fr = '{8'hC1, 8'h00, 8'h20, 8'h02, 8'hAA, 8'hBB};
    send_frame(8'h01);
    chk("err_timing", last_err, 1'b1);
    idle(3);
    chk("bw_err", n_err, 1);
    chk("bw_cnt", wa_q.size(), 2);
    chk("bw_wr", {wa_q[0], wd_q[0], wa_q[1], wd_q[1]}, {16'h0020, 8'hAA, 16'h0021, 8'hBB});
`ifdef CMD_ACK_EN
    wait_tx(1, "nak_cnt");
    chk("nak_wr", tx_q[0], 8'hE1);
`else
    idle(20);
    chk("no_tx_bw", tx_q.size(), 0);
`endif

    // bad-CRC read: no reads at all
    clr();
    fr = '{8'h80, 8'h00, 8'h00, 8'h01};
    send_frame(8'h01);
    idle(30);
    chk("br_rdchg", n_rdchg, 0);
    chk("br_err", n_err, 1);
`ifdef CMD_ACK_EN
    chk("br_nak", {tx_q.size(), tx_q[0]}, {32'd1, 8'hE1});
`else
    chk("no_tx_br", tx_q.size(), 0);
`endif

    // timeout drops a partial frame silently
    clr();
    send(8'h00); send(8'h12); send(8'h34);
    idle(TOUT + 1);
    fr = '{8'h00, 8'h00, 8'h40, 8'h01, 8'h5A};
    send_frame(8'h00);
    idle(3);
    chk("to_cnt", wa_q.size(), 1);
    chk("to_wr", {wa_q[0], wd_q[0]}, {16'h0040, 8'h5A});
    chk("to_err", n_err, 0);

    // address wrap
    clr();
    fr = '{8'h00, 8'hFF, 8'hFF, 8'h02, 8'h01, 8'h02};
    send_frame(8'h00);
    idle(3);
    chk("wrap_cnt", wa_q.size(), 2);
    chk("wrap_wr", {wa_q[0], wd_q[0], wa_q[1], wd_q[1]}, {16'hFFFF, 8'h01, 16'h0000, 8'h02});

    // transmitter back-pressure during read reply
    clr();
    fr = '{8'h80, 8'h00, 8'h05, 8'h02};
    c = crc_of(fr);
    foreach (fr[i]) send(fr[i]);
    hold = 1'b1;
    send(c);
    idle(100);
    chk("hold_notx", tx_q.size(), 0);
    hold = 1'b0;
    wait_tx(3, "hold_cnt");
    rc = crc_of('{8'h05, 8'h06});
    chk("hold_data", {tx_q[0], tx_q[1], tx_q[2]}, {8'h05, 8'h06, rc});

    // reset during second data byte
    clr();
    send(8'h00); send(8'h01); send(8'h00); send(8'h03); send(8'hAA);
    @(negedge clk);
    bus.rx_dat = 8'hBB;
    bus.rx_ce  = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("mr_com", bus.com, 8'hFF);
    chk("mr_adr", {bus.wr_adr, bus.rd_adr}, 32'hFFFF_FFFF);
    chk("mr_strb", {bus.ce_wr_dat, bus.tx_ce, bus.crc_err}, 3'b000);
    @(negedge clk);
    bus.rx_ce = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    chk("mr_post", {bus.ce_wr_dat, bus.tx_ce, bus.crc_err}, 3'b000);
    chk("mr_cnt", wa_q.size(), 1);
    clr();
    fr = '{8'h00, 8'h02, 8'h00, 8'h01, 8'h77};
    send_frame(8'h00);
    idle(3);
    chk("mr_next", {wa_q.size(), wa_q[0], wd_q[0]}, {32'd1, 16'h0200, 8'h77});
    chk("mr_noerr", n_err, 0);

    chk("badadr", n_badadr, 0);
    chk("txviol", n_txviol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
